// File: rtl/wrr4_pkg.sv
// Shared arbiter types: grant FSM encoding and port-index width.
// Used by wrr4 and the other packet arbiters in this slice.
package wrr4_pkg;

   localparam int IDX_W = 2;
   localparam int NPORT = 4;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      HOLD  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wrr4_rr_pick4.sv
// Rotating-priority pick over four requests.
// Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
   import wrr4_pkg::*;
(
   input  logic [3:0] req,
   input  idx_t       ptr,
   output logic       hit,
   output idx_t       idx
);

   idx_t cand;

   always_comb begin
      hit  = 1'b0;
      idx  = ptr;
      cand = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + idx_t'(k);
         if (!hit && req[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/wrr4.sv
// Four-input weighted round-robin packet arbiter.
// Each grant carries a packet quota loaded from wN.
module wrr4
   import wrr4_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s0_TDATA,
   input  logic                    s0_TVALID,
   output logic                    s0_TREADY,
   input  logic                    s0_TLAST,
   input  logic [DATA_WIDTH-1:0]   s1_TDATA,
   input  logic                    s1_TVALID,
   output logic                    s1_TREADY,
   input  logic                    s1_TLAST,
   input  logic [DATA_WIDTH-1:0]   s2_TDATA,
   input  logic                    s2_TVALID,
   output logic                    s2_TREADY,
   input  logic                    s2_TLAST,
   input  logic [DATA_WIDTH-1:0]   s3_TDATA,
   input  logic                    s3_TVALID,
   output logic                    s3_TREADY,
   input  logic                    s3_TLAST,
   input  logic [WEIGHT_WIDTH-1:0] w0,
   input  logic [WEIGHT_WIDTH-1:0] w1,
   input  logic [WEIGHT_WIDTH-1:0] w2,
   input  logic [WEIGHT_WIDTH-1:0] w3,
   output logic [DATA_WIDTH-1:0]   o_TDATA,
   output logic                    o_TVALID,
   input  logic                    o_TREADY,
   output logic                    o_TLAST,
   output logic [1:0]              o_TDEST
);

   typedef logic [DATA_WIDTH-1:0]   data_t;
   typedef logic [WEIGHT_WIDTH-1:0] wgt_t;

   data_t            s_data [NPORT];
   wgt_t             w_a    [NPORT];
   logic [NPORT-1:0] s_valid, s_last, s_ready, req;

   assign s_data = '{s0_TDATA, s1_TDATA, s2_TDATA, s3_TDATA};
   assign w_a    = '{w0, w1, w2, w3};
   assign s_valid = {s3_TVALID, s2_TVALID, s1_TVALID, s0_TVALID};
   assign s_last  = {s3_TLAST, s2_TLAST, s1_TLAST, s0_TLAST};

   arb_state_e state_q, state_d;
   idx_t       ptr_q, ptr_d;
   idx_t       grant_q, grant_d;
   wgt_t       credit_q, credit_d;
   data_t      odata_q, odata_d;
   logic       ovalid_q, ovalid_d;
   logic       olast_q, olast_d;
   idx_t       odest_q, odest_d;

   logic pick_hit;
   idx_t pick_idx;
   logic out_free, g_valid, g_last, acc;

   always_comb begin
      for (int n = 0; n < NPORT; n++)
         req[n] = s_valid[n] && (w_a[n] != '0);
   end

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   assign out_free = !ovalid_q || o_TREADY;
   assign g_valid  = s_valid[grant_q];
   assign g_last   = s_last[grant_q];

   always_comb begin
      s_ready = '0;
      if (state_q != IDLE && out_free)
         s_ready[grant_q] = 1'b1;
   end

   assign acc = s_ready[grant_q] && g_valid;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      olast_d  = olast_q;
      odest_d  = odest_q;

      if (acc) begin
         odata_d  = s_data[grant_q];
         olast_d  = g_last;
         odest_d  = grant_q;
         ovalid_d = 1'b1;
      end else if (o_TREADY) begin
         ovalid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (pick_hit) begin
               grant_d  = pick_idx;
               credit_d = w_a[pick_idx];
               state_d  = BURST;
            end
         end
         BURST, HOLD: begin
            if (acc && g_last) begin
               credit_d = credit_q - wgt_t'(1);
               if (credit_q == wgt_t'(1)) begin
                  state_d = IDLE;
                  ptr_d   = grant_q;
               end else begin
                  state_d = HOLD;
               end
            end else if (acc) begin
               state_d = BURST;
            end else if (state_q == HOLD && !g_valid) begin
               // source went quiet at a boundary: forfeit the rest
               state_d  = IDLE;
               ptr_d    = grant_q;
               credit_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         ptr_q    <= idx_t'(3);
         grant_q  <= '0;
         credit_q <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         odest_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         credit_q <= credit_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         olast_q  <= olast_d;
         odest_q  <= odest_d;
      end
   end

   assign s0_TREADY = s_ready[0];
   assign s1_TREADY = s_ready[1];
   assign s2_TREADY = s_ready[2];
   assign s3_TREADY = s_ready[3];

   assign o_TDATA  = odata_q;
   assign o_TVALID = ovalid_q;
   assign o_TLAST  = olast_q;
   assign o_TDEST  = odest_q;

endmodule

// File: tb/tb_wrr4.sv
// Directed bench for wrr4: reset, rotation, weights, packets,
// forfeit, random stall stream and mid-packet reset.
module tb_wrr4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sd [4];
   logic       sv [4];
   logic       sl [4];
   logic       srdy [4];
   logic [3:0] w [4];
   logic [7:0] o_TDATA;
   logic       o_TVALID, o_TREADY, o_TLAST;
   logic [1:0] o_TDEST;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [3:0] rdy, fire;
   logic       obeat, cv, clast;
   logic [7:0] cdata;
   logic [1:0] cdest;

   always #5 clk = ~clk;

   wrr4 dut (
      .clk(clk), .rst(rst),
      .s0_TDATA(sd[0]), .s0_TVALID(sv[0]), .s0_TREADY(srdy[0]), .s0_TLAST(sl[0]),
      .s1_TDATA(sd[1]), .s1_TVALID(sv[1]), .s1_TREADY(srdy[1]), .s1_TLAST(sl[1]),
      .s2_TDATA(sd[2]), .s2_TVALID(sv[2]), .s2_TREADY(srdy[2]), .s2_TLAST(sl[2]),
      .s3_TDATA(sd[3]), .s3_TVALID(sv[3]), .s3_TREADY(srdy[3]), .s3_TLAST(sl[3]),
      .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]),
      .o_TDATA(o_TDATA), .o_TVALID(o_TVALID), .o_TREADY(o_TREADY),
      .o_TLAST(o_TLAST), .o_TDEST(o_TDEST)
   );

   // Inputs are set at the negedge; capture what the next posedge sees.
   task automatic tick();
      #1;
      for (int n = 0; n < 4; n++) begin
         rdy[n]  = srdy[n];
         fire[n] = sv[n] && srdy[n];
      end
      cv    = o_TVALID;
      cdata = o_TDATA;
      cdest = o_TDEST;
      clast = o_TLAST;
      obeat = o_TVALID && o_TREADY;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_inputs();
      for (int n = 0; n < 4; n++) begin
         sv[n] = 1'b0;
         sl[n] = 1'b0;
         sd[n] = 8'h00;
         w[n]  = 4'd1;
      end
      o_TREADY = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      checks++;
      if ({o_TVALID, o_TLAST, o_TDEST, o_TDATA} !== 12'h000) begin
         errors++;
         $display("FAIL reset_out got v%b l%b d%0d data%h want all 0",
                  o_TVALID, o_TLAST, o_TDEST, o_TDATA);
      end
      checks++;
      if ({srdy[3], srdy[2], srdy[1], srdy[0]} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready got %b%b%b%b want 0000",
                  srdy[3], srdy[2], srdy[1], srdy[0]);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_zero_weights();
      logic any;
      do_reset();
      any = 1'b0;
      for (int n = 0; n < 4; n++) begin
         w[n]  = 4'd0;
         sv[n] = 1'b1;
         sl[n] = 1'b1;
      end
      repeat (6) begin
         tick();
         if (rdy != 4'b0000 || cv) any = 1'b1;
      end
      checks++;
      if (any !== 1'b0) begin
         errors++;
         $display("FAIL zero_weights got activity=%b want 0", any);
      end
   endtask

   task automatic test_equal();
      logic [1:0] exp_d [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [1:0] bd [5];
      int bc [5];
      int nb = 0;
      do_reset();
      for (int n = 0; n < 4; n++) begin
         sv[n] = 1'b1;
         sl[n] = 1'b1;
         sd[n] = 8'(n);
      end
      for (int t = 0; t < 40 && nb < 5; t++) begin
         tick();
         if (obeat) begin
            bd[nb] = cdest;
            bc[nb] = cyc;
            nb++;
         end
      end
      checks++;
      if (nb != 5) begin
         errors++;
         $display("FAIL equal_count got %0d beats want 5", nb);
      end
      for (int i = 0; i < nb; i++) begin
         checks++;
         if (bd[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL equal_dest[%0d] got %0d want %0d", i, bd[i], exp_d[i]);
         end
      end
      for (int i = 1; i < nb; i++) begin
         checks++;
         if (bc[i] - bc[i-1] != 2) begin
            errors++;
            $display("FAIL equal_gap[%0d] got %0d want 2", i, bc[i] - bc[i-1]);
         end
      end
   endtask

   task automatic test_weights();
      logic [1:0] exp_d [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
      logic [1:0] bd [8];
      int nb = 0;
      logic s23 = 1'b0;
      do_reset();
      w[0] = 4'd3;
      w[1] = 4'd1;
      w[2] = 4'd0;
      w[3] = 4'd0;
      for (int n = 0; n < 4; n++) begin
         sv[n] = 1'b1;
         sl[n] = 1'b1;
         sd[n] = 8'(8'h40 + n);
      end
      for (int t = 0; t < 60 && nb < 8; t++) begin
         tick();
         if (rdy[2] || rdy[3]) s23 = 1'b1;
         if (obeat) begin
            bd[nb] = cdest;
            nb++;
         end
      end
      checks++;
      if (nb != 8) begin
         errors++;
         $display("FAIL weights_count got %0d beats want 8", nb);
      end
      for (int i = 0; i < nb; i++) begin
         checks++;
         if (bd[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL weights_dest[%0d] got %0d want %0d", i, bd[i], exp_d[i]);
         end
      end
      checks++;
      if (s23 !== 1'b0) begin
         errors++;
         $display("FAIL weights_s23_ready got %b want 0", s23);
      end
   endtask

   task automatic test_packet();
      logic [1:0] qd [$];
      logic [7:0] qdat [$];
      logic       ql [$];
      int         qc [$];
      int cnt0 = 0, cnt1 = 0, n1 = 0, extra = 0, first = -1;
      do_reset();
      for (int t = 0; t < 60 && extra < 3; t++) begin
         sv[0] = 1'b1;
         sl[0] = 1'b1;
         sd[0] = 8'(cnt0 * 4);
         sv[1] = (cnt1 < 5);
         sl[1] = (cnt1 == 4);
         sd[1] = 8'(cnt1 * 4 + 1);
         tick();
         if (fire[0]) cnt0++;
         if (fire[1]) cnt1++;
         if (obeat) begin
            qd.push_back(cdest);
            qdat.push_back(cdata);
            ql.push_back(clast);
            qc.push_back(cyc);
            if (cdest == 2'd1) n1++;
         end
         if (n1 == 5) extra++;
      end
      for (int i = 0; i < qd.size(); i++)
         if (first < 0 && qd[i] == 2'd1) first = i;
      checks++;
      if (first < 0 || first + 5 > qd.size()) begin
         errors++;
         $display("FAIL packet_found got first=%0d beats=%0d want 5 s1 beats",
                  first, qd.size());
      end else begin
         for (int j = 0; j < 5; j++) begin
            checks++;
            if (qd[first+j] !== 2'd1 || qdat[first+j] !== 8'(j * 4 + 1) ||
                ql[first+j] !== (j == 4) || qc[first+j] != qc[first] + j) begin
               errors++;
               $display("FAIL packet_flit[%0d] got d%0d data%h l%b c%0d want d1 data%h l%b c%0d",
                        j, qd[first+j], qdat[first+j], ql[first+j], qc[first+j],
                        8'(j * 4 + 1), (j == 4), qc[first] + j);
            end
         end
      end
   endtask

   task automatic test_forfeit();
      do_reset();
      w[2]  = 4'd2;
      sv[2] = 1'b1;
      sl[2] = 1'b1;
      sd[2] = 8'h22;
      tick();
      checks++;
      if (rdy !== 4'b0000) begin
         errors++;
         $display("FAIL forfeit_idle_rdy got %b want 0000", rdy);
      end
      tick();
      checks++;
      if (rdy !== 4'b0100 || fire !== 4'b0100) begin
         errors++;
         $display("FAIL forfeit_burst got rdy%b fire%b want 0100/0100", rdy, fire);
      end
      sv[2] = 1'b0;
      sv[0] = 1'b1; sl[0] = 1'b1; sd[0] = 8'h00;
      sv[3] = 1'b1; sl[3] = 1'b1; sd[3] = 8'h33;
      tick();
      checks++;
      if (rdy !== 4'b0100 || !obeat || cdest !== 2'd2 || cdata !== 8'h22) begin
         errors++;
         $display("FAIL forfeit_hold got rdy%b beat%b d%0d data%h want 0100 1 2 22",
                  rdy, obeat, cdest, cdata);
      end
      tick();
      checks++;
      if (rdy !== 4'b0000) begin
         errors++;
         $display("FAIL forfeit_to_idle got rdy%b want 0000", rdy);
      end
      tick();
      checks++;
      if (rdy !== 4'b1000) begin
         errors++;
         $display("FAIL forfeit_next_grant got rdy%b want 1000", rdy);
      end
      sv[0] = 1'b0;
      sv[3] = 1'b0;
      tick();
      checks++;
      if (!obeat || cdest !== 2'd3 || cdata !== 8'h33) begin
         errors++;
         $display("FAIL forfeit_out3 got beat%b d%0d data%h want 1 3 33",
                  obeat, cdest, cdata);
      end
   endtask

   task automatic test_random();
      int cnt [4] = '{0, 0, 0, 0};
      int rcv [4] = '{0, 0, 0, 0};
      logic       inpkt = 1'b0, stall = 1'b0;
      logic [1:0] pdest = 2'd0;
      logic [11:0] held = '0;
      logic [1:0] d;
      do_reset();
      for (int n = 0; n < 4; n++) w[n] = 4'(1 + $urandom_range(2));
      fire = 4'b0000;
      for (int t = 0; t < 700; t++) begin
         if (t < 690) o_TREADY = 1'($urandom_range(1));
         else o_TREADY = 1'b1;
         for (int n = 0; n < 4; n++) begin
            if (t >= 690) begin
               sv[n] = 1'b0;
            end else if (!sv[n] || fire[n]) begin
               sv[n] = 1'($urandom_range(1));
               sd[n] = 8'(cnt[n] * 4 + n);
               sl[n] = ($urandom_range(2) == 0);
            end
         end
         tick();
         for (int n = 0; n < 4; n++) if (fire[n]) cnt[n]++;
         if (stall) begin
            checks++;
            if ({cv, clast, cdest, cdata} !== held) begin
               errors++;
               $display("FAIL rand_stall t=%0d got %h want %h",
                        t, {cv, clast, cdest, cdata}, held);
            end
         end
         stall = cv && !o_TREADY;
         held = {cv, clast, cdest, cdata};
         if (obeat) begin
            d = cdest;
            checks++;
            if (cdata !== 8'(rcv[d] * 4 + d) || (inpkt && d !== pdest)) begin
               errors++;
               $display("FAIL rand_beat t=%0d got d%0d data%h want data%h pkt_dest%0d",
                        t, d, cdata, 8'(rcv[d] * 4 + d), pdest);
            end
            rcv[d]++;
            inpkt = !clast;
            pdest = d;
         end
      end
      for (int n = 0; n < 4; n++) begin
         checks++;
         if (rcv[n] != cnt[n] || cnt[n] == 0) begin
            errors++;
            $display("FAIL rand_count[%0d] got out=%0d want in=%0d (nonzero)",
                     n, rcv[n], cnt[n]);
         end
      end
      fire = 4'b0000;
   endtask

   task automatic test_reset_mid();
      int n3 = 0, c3 = 0;
      logic got = 1'b0;
      do_reset();
      sv[3] = 1'b1;
      sl[3] = 1'b0;
      for (int t = 0; t < 20 && n3 < 2; t++) begin
         sd[3] = 8'(c3 * 4 + 3);
         tick();
         if (fire[3]) c3++;
         if (obeat && cdest == 2'd3) n3++;
      end
      #1;
      checks++;
      if (o_TVALID !== 1'b1 || n3 != 2) begin
         errors++;
         $display("FAIL rstmid_inflight got v%b beats%0d want 1 2", o_TVALID, n3);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (o_TVALID !== 1'b0 || {srdy[3], srdy[2], srdy[1], srdy[0]} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_async got v%b rdy%b%b%b%b want 0 0000",
                  o_TVALID, srdy[3], srdy[2], srdy[1], srdy[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int n = 1; n < 4; n++) begin
         sv[n] = 1'b1;
         sl[n] = 1'b1;
         sd[n] = 8'(8'h80 + n);
      end
      sv[0] = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         tick();
         if (obeat) begin
            got = 1'b1;
            checks++;
            if (cdest !== 2'd1 || cdata !== 8'h81) begin
               errors++;
               $display("FAIL rstmid_first got d%0d data%h want 1 81", cdest, cdata);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rstmid_timeout got no beat want one within 10 cycles");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_weights();
      test_equal();
      test_weights();
      test_packet();
      test_forfeit();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
